// File: rtl/brake_tilt_detector.sv
// Block-averages accelerometer samples and derives debounced brake level, tilt status and freshness.
// Optional tilt path (z averaging, tilt counter, tilt_valid) is built only when BRAKE_TILT_DETECT_EN is defined.
module brake_tilt_detector #(
    parameter int unsigned AVG_LOG2     = 2,
    parameter logic [15:0] SOFT_TH      = 16'd200,
    parameter logic [15:0] HARD_TH      = 16'd600,
    parameter int unsigned HOLD_BLOCKS  = 4,
    parameter logic [15:0] TILT_TH      = 16'd300,
    parameter int unsigned TILT_BLOCKS  = 8,
    parameter int unsigned STALE_CYCLES = 100000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_z,
    output logic [1:0]  brake_intensity,
    output logic        acc_valid,
    output logic        tilt_valid
);

    localparam int unsigned N      = 1 << AVG_LOG2;
    localparam int unsigned SUM_W  = 16 + AVG_LOG2;
    localparam int unsigned CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned ST_W   = $clog2(STALE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_BLOCKS + 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALE = 2'd2
    } state_t;

    state_t                   state_r, state_s;
    logic                     ready_r;
    logic [ST_W-1:0]          stale_cnt_r;
    logic signed [SUM_W-1:0]  sum_x_r;
    logic [CNT_W-1:0]         cnt_r;
    logic                     blk_done_r;
    logic                     cls_vld_r;
    logic [1:0]               cls_r;
    logic [1:0]               level_r, level_s;
    logic [HOLD_W-1:0]        hold_r, hold_s;
    logic                     acc_valid_r, acc_valid_s;
    logic                     accept_s, stale_hit_s, last_s;
    logic signed [15:0]       avg_x_s;
    logic signed [16:0]       avg_x_ext_s, decel_s;
    logic [1:0]               class_s;

    assign accept_s    = sample_valid && ready_r;
    assign last_s      = (cnt_r == CNT_W'(N - 1));
    // Limit is reached on this edge unless a sample is accepted on it.
    assign stale_hit_s = !accept_s && (state_r != ST_STALE) &&
                         (stale_cnt_r == ST_W'(STALE_CYCLES - 1));

    assign sample_ready    = ready_r;
    assign brake_intensity = level_r;
    assign acc_valid       = acc_valid_r;

    // Handshake: one bubble cycle after every accepted sample.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= !accept_s;
        end
    end

    // Staleness timer, cleared by accepts and saturating at the limit.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            stale_cnt_r <= '0;
        end else if (accept_s) begin
            stale_cnt_r <= '0;
        end else if (stale_cnt_r != ST_W'(STALE_CYCLES)) begin
            stale_cnt_r <= stale_cnt_r + ST_W'(1);
        end
    end

    // X accumulator and sample counter; the sum clears the cycle after the block completes.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_x_r    <= '0;
            cnt_r      <= '0;
            blk_done_r <= 1'b0;
        end else if (stale_hit_s) begin
            sum_x_r    <= '0;
            cnt_r      <= '0;
            blk_done_r <= 1'b0;
        end else if (accept_s) begin
            sum_x_r    <= sum_x_r + SUM_W'($signed(sample_x));
            cnt_r      <= last_s ? '0 : cnt_r + CNT_W'(1);
            blk_done_r <= last_s;
        end else if (blk_done_r) begin
            sum_x_r    <= '0;
            blk_done_r <= 1'b0;
        end
    end

    // Brake classification in 17-bit math so that -32768 negates without wrapping.
    always_comb begin
        avg_x_s     = 16'(sum_x_r >>> AVG_LOG2);
        avg_x_ext_s = 17'(avg_x_s);
        decel_s     = 17'sd0 - avg_x_ext_s;
        if (decel_s >= $signed({1'b0, HARD_TH})) begin
            class_s = 2'b11;
        end else if (decel_s >= $signed({1'b0, SOFT_TH})) begin
            class_s = 2'b01;
        end else begin
            class_s = 2'b00;
        end
    end

    // Registered block class, valid for one cycle after the block completes.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_vld_r <= 1'b0;
            cls_r     <= 2'b00;
        end else begin
            cls_vld_r <= blk_done_r && !stale_hit_s;
            if (blk_done_r) begin
                cls_r <= class_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        if (stale_hit_s) begin
            state_s = ST_STALE;
        end else begin
            case (state_r)
                ST_INIT:  state_s = cls_vld_r ? ST_RUN : ST_INIT;
                ST_RUN:   state_s = ST_RUN;
                ST_STALE: state_s = accept_s ? ST_INIT : ST_STALE;
                default:  state_s = ST_INIT;
            endcase
        end
    end

    // FSM output logic: brake level with hold-off debounce and freshness flag.
    always_comb begin
        level_s     = level_r;
        hold_s      = hold_r;
        acc_valid_s = acc_valid_r;
        if (stale_hit_s) begin
            level_s     = 2'b00;
            hold_s      = '0;
            acc_valid_s = 1'b0;
        end else if (cls_vld_r) begin
            acc_valid_s = 1'b1;
            if ((cls_r >= level_r) || (hold_r == HOLD_W'(HOLD_BLOCKS - 1))) begin
                level_s = cls_r;
                hold_s  = '0;
            end else begin
                level_s = level_r;
                hold_s  = hold_r + HOLD_W'(1);
            end
        end else begin
            acc_valid_s = acc_valid_r;
        end
    end

    // Output and hold registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r     <= 2'b00;
            hold_r      <= '0;
            acc_valid_r <= 1'b0;
        end else begin
            level_r     <= level_s;
            hold_r      <= hold_s;
            acc_valid_r <= acc_valid_s;
        end
    end

`ifdef BRAKE_TILT_DETECT_EN
    localparam int unsigned TILT_W = $clog2(TILT_BLOCKS + 1);

    logic signed [SUM_W-1:0] sum_z_r;
    logic signed [15:0]      avg_z_s;
    logic signed [16:0]      avg_z_ext_s;
    logic [16:0]             abs_z_s;
    logic                    tilted_s, tilted_r;
    logic [TILT_W-1:0]       tilt_cnt_r, tilt_cnt_s;
    logic                    tilt_valid_r, tilt_valid_s;

    assign tilt_valid = tilt_valid_r;

    // Z accumulator, cleared in lockstep with the x accumulator.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_z_r <= '0;
        end else if (stale_hit_s) begin
            sum_z_r <= '0;
        end else if (accept_s) begin
            sum_z_r <= sum_z_r + SUM_W'($signed(sample_z));
        end else if (blk_done_r) begin
            sum_z_r <= '0;
        end
    end

    // Tilt classification on the block magnitude of z.
    always_comb begin
        avg_z_s     = 16'(sum_z_r >>> AVG_LOG2);
        avg_z_ext_s = 17'(avg_z_s);
        if (avg_z_ext_s[16]) begin
            abs_z_s = 17'(17'sd0 - avg_z_ext_s);
        end else begin
            abs_z_s = 17'(avg_z_ext_s);
        end
        tilted_s = (abs_z_s < {1'b0, TILT_TH});
    end

    // Registered tilt class alongside the brake class.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tilted_r <= 1'b0;
        end else if (blk_done_r) begin
            tilted_r <= tilted_s;
        end
    end

    // Tilt debounce: saturating count of consecutive tilted blocks.
    always_comb begin
        tilt_cnt_s   = tilt_cnt_r;
        tilt_valid_s = tilt_valid_r;
        if (stale_hit_s) begin
            tilt_cnt_s   = '0;
            tilt_valid_s = 1'b0;
        end else if (cls_vld_r) begin
            if (tilted_r) begin
                if (tilt_cnt_r != TILT_W'(TILT_BLOCKS)) begin
                    tilt_cnt_s = tilt_cnt_r + TILT_W'(1);
                end else begin
                    tilt_cnt_s = tilt_cnt_r;
                end
                tilt_valid_s = (tilt_cnt_s == TILT_W'(TILT_BLOCKS));
            end else begin
                tilt_cnt_s   = '0;
                tilt_valid_s = 1'b0;
            end
        end else begin
            tilt_valid_s = tilt_valid_r;
        end
    end

    // Tilt counter and output register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tilt_cnt_r   <= '0;
            tilt_valid_r <= 1'b0;
        end else begin
            tilt_cnt_r   <= tilt_cnt_s;
            tilt_valid_r <= tilt_valid_s;
        end
    end
`else
    logic [15:0] unused_z_s;

    assign unused_z_s = sample_z;
    assign tilt_valid = 1'b0;
`endif

endmodule

// File: tb/tb_brake_tilt_detector.sv
// Bench for brake_tilt_detector: directed scenarios plus randomized traffic against a block-level reference model.
// The staleness limit is shortened so that stale scenarios fit in a short run.
module tb_brake_tilt_detector;

    localparam int STALE = 300;
`ifdef BRAKE_TILT_DETECT_EN
    localparam bit TILT_ON = 1'b1;
`else
    localparam bit TILT_ON = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [15:0] sample_x = 16'd0;
    logic [15:0] sample_z = 16'd0;
    logic [1:0]  brake_intensity;
    logic        acc_valid;
    logic        tilt_valid;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int m_qx[$];
    int m_qz[$];
    bit m_ready, m_acc, m_tiltv, m_is_stale, m_pend_tilted;
    int m_level, m_hold, m_tilt_cnt, m_stale, m_cycle, m_due, m_pend_cls;

    always #5 sys_clk = ~sys_clk;

    brake_tilt_detector #(.STALE_CYCLES(STALE)) dut (
        .sys_clk(sys_clk),
        .rst_n(rst_n),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .sample_x(sample_x),
        .sample_z(sample_z),
        .brake_intensity(brake_intensity),
        .acc_valid(acc_valid),
        .tilt_valid(tilt_valid)
    );

    function automatic int classify(input int avg);
        int decel;
        decel = -avg;
        if (decel >= 600) return 3;
        else if (decel >= 200) return 1;
        else return 0;
    endfunction

    task automatic model_clear();
        m_qx.delete();
        m_qz.delete();
        m_level = 0; m_hold = 0; m_tilt_cnt = 0; m_acc = 0; m_tiltv = 0;
        m_due = -1;
    endtask

    // Model: one step per clock edge, reset clears everything at once.
    initial begin
        model_clear();
        m_ready = 0; m_is_stale = 0; m_stale = 0; m_cycle = 0;
        forever begin
            @(posedge sys_clk or negedge rst_n);
            if (!rst_n) begin
                model_clear();
                m_ready = 0; m_is_stale = 0; m_stale = 0; m_cycle = 0;
            end else begin
                bit acc;
                int sx, sz, avgx, avgz, absz;
                acc = sample_valid && m_ready;
                m_cycle++;
                if (m_due == m_cycle) begin
                    m_acc = 1;
                    if (m_pend_cls >= m_level || m_hold + 1 == 4) begin
                        m_level = m_pend_cls; m_hold = 0;
                    end else begin
                        m_hold++;
                    end
                    if (m_pend_tilted) begin
                        m_tilt_cnt = (m_tilt_cnt < 8) ? m_tilt_cnt + 1 : 8;
                        m_tiltv = (m_tilt_cnt == 8);
                    end else begin
                        m_tilt_cnt = 0; m_tiltv = 0;
                    end
                end
                if (acc) m_stale = 0;
                else if (m_stale < STALE) begin
                    m_stale++;
                    if (m_stale == STALE && !m_is_stale) begin
                        m_is_stale = 1;
                        model_clear();
                    end
                end
                if (acc) begin
                    m_is_stale = 0;
                    m_qx.push_back(int'($signed(sample_x)));
                    m_qz.push_back(int'($signed(sample_z)));
                    if (m_qx.size() == 4) begin
                        sx = 0; sz = 0;
                        for (int i = 0; i < 4; i++) begin sx += m_qx[i]; sz += m_qz[i]; end
                        avgx = sx >>> 2;
                        avgz = sz >>> 2;
                        absz = (avgz < 0) ? -avgz : avgz;
                        m_pend_cls = classify(avgx);
                        m_pend_tilted = (absz < 300);
                        m_due = m_cycle + 2;
                        m_qx.delete();
                        m_qz.delete();
                    end
                end
                m_ready = !acc;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            logic [1:0] eb;
            bit et;
            @(negedge sys_clk);
            eb = 2'(m_level);
            et = TILT_ON ? m_tiltv : 1'b0;
            n_cmp++;
            if (sample_ready !== m_ready || brake_intensity !== eb ||
                acc_valid !== m_acc || tilt_valid !== et) begin
                n_err++;
                $display("FAIL cycle_check t=%0t got rdy=%b brk=%b acc=%b tilt=%b want rdy=%b brk=%b acc=%b tilt=%b",
                         $time, sample_ready, brake_intensity, acc_valid, tilt_valid, m_ready, eb, m_acc, et);
            end
        end
    end

    task automatic check_lit(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic send(input int x, input int z);
        int n;
        @(negedge sys_clk);
        sample_valid = 1'b1;
        sample_x = 16'(x);
        sample_z = 16'(z);
        n = 0;
        while (!sample_ready && n < 8) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 8) begin
            n_err++;
            $display("FAIL ready_timeout got ready=%b want 1 within 8 cycles", sample_ready);
        end else begin
            @(negedge sys_clk);
        end
        sample_valid = 1'b0;
    endtask

    task automatic send_block(input int x, input int z);
        for (int i = 0; i < 4; i++) send(x, z);
        repeat (2) @(negedge sys_clk);
    endtask

    function automatic int rand_x();
        case ($urandom_range(0, 7))
            0: return -32768;
            1: return 32767;
            2: return -600;
            3: return -599;
            4: return -200;
            5: return -199;
            6: return 0;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    function automatic int rand_z();
        case ($urandom_range(0, 6))
            0: return 299;
            1: return 300;
            2: return -299;
            3: return -300;
            4: return -32768;
            5: return 0;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    initial begin
        int bx[5] = '{-599, -600, -199, -200, 199};
        int bz[5] = '{299, 300, -299, -300, -32768};
        repeat (3) @(negedge sys_clk);
        check_lit("reset_brake", int'(brake_intensity), 0);
        check_lit("reset_acc", int'(acc_valid), 0);
        check_lit("reset_tilt", int'(tilt_valid), 0);
        check_lit("reset_ready", int'(sample_ready), 0);
        rst_n = 1'b1;
        @(negedge sys_clk);
        check_lit("ready_after_release", int'(sample_ready), 1);

        send_block(-300, 1000);
        check_lit("soft_brake", int'(brake_intensity), 1);
        check_lit("soft_acc", int'(acc_valid), 1);
        check_lit("soft_tilt", int'(tilt_valid), 0);
        send_block(-700, 1000);
        check_lit("hard_rise", int'(brake_intensity), 3);
        for (int i = 0; i < 3; i++) begin
            send_block(0, 1000);
            check_lit("hard_hold", int'(brake_intensity), 3);
        end
        send_block(0, 1000);
        check_lit("hard_release", int'(brake_intensity), 0);

        for (int i = 0; i < 7; i++) begin
            send_block(0, 100);
            check_lit("tilt_pending", int'(tilt_valid), 0);
        end
        send_block(0, 100);
        check_lit("tilt_rise", int'(tilt_valid), int'(TILT_ON));
        send_block(0, 1000);
        check_lit("tilt_drop", int'(tilt_valid), 0);

        for (int i = 0; i < 5; i++) send_block(bx[i], bz[i]);
        send_block(-32768, 1000);
        check_lit("min_x_hard", int'(brake_intensity), 3);

        repeat (STALE + 5) @(negedge sys_clk);
        check_lit("stale_acc", int'(acc_valid), 0);
        check_lit("stale_brake", int'(brake_intensity), 0);
        send_block(-300, 1000);
        check_lit("recover_brake", int'(brake_intensity), 1);
        check_lit("recover_acc", int'(acc_valid), 1);

        send(-2000, 1000);
        send(-2000, 1000);
        #2 rst_n = 1'b0;
        #1;
        check_lit("async_rst_acc", int'(acc_valid), 0);
        check_lit("async_rst_brake", int'(brake_intensity), 0);
        check_lit("async_rst_ready", int'(sample_ready), 0);
        @(negedge sys_clk);
        #2 rst_n = 1'b1;
        send_block(-300, 1000);
        check_lit("post_rst_brake", int'(brake_intensity), 1);
        check_lit("post_rst_acc", int'(acc_valid), 1);

        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                repeat (STALE + $urandom_range(0, 20)) @(negedge sys_clk);
            end else if (r < 5) begin
                @(negedge sys_clk);
                #2 rst_n = 1'b0;
                @(negedge sys_clk);
                #2 rst_n = 1'b1;
            end else begin
                send(rand_x(), rand_z());
                repeat ($urandom_range(0, 2)) @(negedge sys_clk);
            end
        end

        repeat (5) @(negedge sys_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
